axis_pkt_master: RTL and testbench
==================================

Name: axis_pkt_master

Overview:
AXI-Stream transmitter (master) that generates one packet per accepted command. Each packet carries an incrementing data pattern and asserts m_tlast on its final beat. It is the source end of the stream link and drives our AXI-ST slave sink in the stream datapath and in loopback benches. It obeys full AXI-Stream valid/ready rules under arbitrary backpressure.

Parameters:
DATA_W, 32, width of m_tdata and seed.
LEN_W, 16, width of pkt_len, the beat counter and the remaining-beat counter.
CNT_W, 16, width of the pkt_count statistics counter.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous active-low reset.
start  in  1  command strobe, sampled on clk.
pkt_len  in  LEN_W  beats in packet; sampled with start.
seed  in  DATA_W  data of the first beat; sampled with start.
busy  out  1  high while a packet is in progress (state SEND).
done  out  1  one-cycle pulse after the last beat handshakes.
beat_idx  out  LEN_W  index of the beat currently presented, 0-based.
pkt_count  out  CNT_W  number of completed packets; wraps.
m_tdata  out  DATA_W  stream data.
m_tvalid  out  1  stream valid.
m_tlast  out  1  marks the final beat.
m_tready  in  1  sink ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - m_tvalid, m_tlast, busy, done = 0.
  - m_tdata, beat_idx, pkt_count = 0.
  - An in-flight packet is discarded. There is no resume after reset.
- All outputs are registered. There is no combinational path from m_tready to any output.
- A handshake occurs on any rising edge where m_tvalid=1 and m_tready=1.
- FSM states: IDLE, SEND.
- IDLE:
  - If start=1 and pkt_len!=0: latch rem=pkt_len, m_tdata=seed, beat_idx=0, m_tlast=(pkt_len==1), m_tvalid=1, busy=1, go to SEND.
  - First beat latency: m_tvalid rises in the cycle after start.
  - start=1 with pkt_len=0 is ignored: no valid, no done, no count change.
- SEND:
  - While m_tvalid=1 and m_tready=0: m_tdata, m_tlast and beat_idx hold stable. m_tvalid never drops before a handshake.
  - On a non-last handshake: m_tdata+=1 (mod 2^DATA_W, wraps), beat_idx+=1, rem-=1, m_tlast=(rem_after==1). m_tvalid stays 1, so back-to-back beats run at 1 beat/cycle with no bubble.
  - On the last handshake (m_tlast=1): next cycle m_tvalid=0, m_tlast=0, busy=0, done=1 for one cycle, pkt_count+=1 (wraps), state goes to IDLE.
  - start is ignored in SEND. No command queueing.
- done is high during the first IDLE cycle. A start in that same cycle is accepted, so the minimum inter-packet gap is 1 idle cycle of m_tvalid=0.
- m_tvalid never depends on m_tready in the same cycle.
- A packet of pkt_len=N produces exactly N beats. m_tlast is high on beat N-1 only.

Test Plan:
- No backpressure: m_tready=1, start with pkt_len=4, seed=0x10. Required: m_tvalid high for 4 consecutive cycles starting 1 cycle after start; m_tdata 0x10,0x11,0x12,0x13; m_tlast only on 0x13; done pulses once the cycle after; pkt_count=1.
- Backpressure: pkt_len=3, seed=0xA0, m_tready toggled 0,0,1,0,1,1. Required: m_tdata/m_tlast/beat_idx stable while m_tready=0; beats 0xA0,0xA1,0xA2 each transferred exactly once; m_tvalid never drops mid-packet.
- Single beat and zero length: pkt_len=1, seed=0x5 gives one beat with m_tlast=1 and done. Then pkt_len=0 with start gives no m_tvalid, no done, pkt_count unchanged.
- Wrap and start-while-busy: seed=0xFFFFFFFE, pkt_len=4 gives data FFFFFFFE, FFFFFFFF, 0, 1. A second start mid-packet with pkt_len=9 is ignored; exactly 4 beats are sent.
- Back-to-back commands: start asserted in the done cycle with pkt_len=2, seed=0x40. Required: second packet 0x40,0x41 begins after exactly one m_tvalid=0 cycle; pkt_count=2.
- Reset mid-operation: rst=0 asynchronously during beat 2 of 5. Required: m_tvalid, m_tlast, busy and done drop immediately, with no clock edge needed; pkt_count=0. After release, a new start sends a full packet from beat_idx=0.

Source files
------------

// File: rtl/axis_pkt_master.sv
// AXI-Stream packet source: one packet per accepted command, incrementing data
// from the command seed, m_tlast on the final beat. Every output is registered.
module axis_pkt_master #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  beat_idx,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_nx;
  logic [LEN_W-1:0]  rem, rem_nx, idx_nx;
  logic [DATA_W-1:0] data_nx;
  logic [CNT_W-1:0]  cnt_nx;
  logic              last_nx, valid_nx, busy_nx, done_nx;
  logic              hs;

  assign hs = m_tvalid & m_tready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rem       <= '0;
      m_tdata   <= '0;
      beat_idx  <= '0;
      m_tlast   <= 1'b0;
      m_tvalid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pkt_count <= '0;
    end else begin
      state     <= state_nx;
      rem       <= rem_nx;
      m_tdata   <= data_nx;
      beat_idx  <= idx_nx;
      m_tlast   <= last_nx;
      m_tvalid  <= valid_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      pkt_count <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    data_nx  = m_tdata;
    idx_nx   = beat_idx;
    last_nx  = m_tlast;
    valid_nx = m_tvalid;
    busy_nx  = busy;
    done_nx  = 1'b0;
    cnt_nx   = pkt_count;
    case (state)
      IDLE: begin
        // zero-length commands are dropped without any visible effect
        if (start && pkt_len != '0) begin
          rem_nx   = pkt_len;
          data_nx  = seed;
          idx_nx   = '0;
          last_nx  = (pkt_len == LEN_W'(1));
          valid_nx = 1'b1;
          busy_nx  = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (m_tlast) begin
            valid_nx = 1'b0;
            last_nx  = 1'b0;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            cnt_nx   = pkt_count + CNT_W'(1);
            state_nx = IDLE;
          end else begin
            // rem counts the presented beat too, so 2 left means the next is last
            data_nx = m_tdata + DATA_W'(1);
            idx_nx  = beat_idx + LEN_W'(1);
            rem_nx  = rem - LEN_W'(1);
            last_nx = (rem == LEN_W'(2));
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_pkt_master.sv
// Bench for axis_pkt_master: table vectors, hand-written corner sequences and
// randomized packets under random backpressure, checked against a beat-list model.
module tb_axis_pkt_master;

  logic        clk, rst, start, busy, done, m_tvalid, m_tlast, m_tready;
  logic [15:0] pkt_len, beat_idx, pkt_count;
  logic [31:0] seed, m_tdata;

  axis_pkt_master #(.DATA_W(32), .LEN_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .pkt_len(pkt_len), .seed(seed),
    .busy(busy), .done(done), .beat_idx(beat_idx), .pkt_count(pkt_count),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        last;
    logic [15:0] idx;
  } beat_t;

  typedef struct {
    logic [15:0] len;
    logic [31:0] seed;
    bit          rnd;
    int          busy_k;
    int          exp_beats;
    logic [31:0] exp_first;
    logic [31:0] exp_lastd;
  } vec_t;

  int     n_chk = 0, n_fail = 0;
  int     exp_cnt = 0, exp_done = 0, done_total = 0;
  bit     rnd_rdy = 0;
  bit     rdy_pat[$];
  beat_t  got[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_pat.size() > 0) m_tready = rdy_pat.pop_front();
    else if (rnd_rdy)       m_tready = ($urandom_range(0, 2) != 0);
    else                    m_tready = 1'b1;
  endtask

  // Monitor: records transferred beats, checks hold-under-stall, counts done pulses.
  bit          prev_stall = 0;
  logic        p_last;
  logic [15:0] p_idx;
  logic [31:0] p_data;
  always @(negedge clk) begin
    if (!rst) prev_stall = 0;
    else begin
      if (prev_stall)
        check("stall_hold", {14'd0, m_tvalid, m_tlast, beat_idx, m_tdata},
              {14'd0, 1'b1, p_last, p_idx, p_data});
      prev_stall = m_tvalid && !m_tready;
      p_last = m_tlast; p_idx = beat_idx; p_data = m_tdata;
      if (m_tvalid && m_tready) got.push_back('{m_tdata, m_tlast, beat_idx});
      if (done) done_total++;
    end
  end

  // Issue one command and wait for its done; returns cycles from first beat to done.
  task automatic send(input logic [15:0] len, input logic [31:0] sd, input int busy_k,
                      output int n);
    beat_t exp[$];
    got.delete();
    start = 1'b1; pkt_len = len; seed = sd;
    tick();
    start = 1'b0;
    n = 0;
    check("first_valid", m_tvalid, len != 0);
    if (len == 0) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        check("zero_len_quiet", {m_tvalid, done}, 2'b00);
      end
      check("zero_len_cnt", pkt_count, exp_cnt[15:0]);
      check("zero_len_beats", got.size(), 0);
      return;
    end
    check("busy", busy, 1'b1);
    while (!done && n < 500) begin
      if (n == busy_k) begin start = 1'b1; pkt_len = 16'd9; end
      tick();
      start = 1'b0;
      n++;
    end
    check("done_seen", done, 1'b1);
    check("done_cycle_valid", {m_tvalid, m_tlast, busy}, 3'b000);
    exp_cnt++;
    exp_done++;
    check("pkt_count", pkt_count, exp_cnt[15:0]);
    for (int i = 0; i < len; i++)
      exp.push_back('{sd + 32'(i), (i == len - 1), 16'(i)});
    check("beat_total", got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("beat%0d", i), {got[i].last, got[i].idx, got[i].d},
            {exp[i].last, exp[i].idx, exp[i].d});
  endtask

  vec_t vecs[6];
  int   n;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'd4, 32'h10,       1'b0, -1, 4, 32'h10,       32'h13};
    vecs[1] = '{16'd1, 32'h5,        1'b0, -1, 1, 32'h5,        32'h5};
    vecs[2] = '{16'd0, 32'h77,       1'b0, -1, 0, 32'h0,        32'h0};
    vecs[3] = '{16'd4, 32'hFFFFFFFE, 1'b0,  1, 4, 32'hFFFFFFFE, 32'h1};
    vecs[4] = '{16'd7, 32'h1000,     1'b1, -1, 7, 32'h1000,     32'h1006};
    vecs[5] = '{16'd2, 32'h40,       1'b0, -1, 2, 32'h40,       32'h41};

    rst = 1'b0; start = 1'b0; pkt_len = '0; seed = '0; m_tready = 1'b0;
    repeat (3) tick();
    check("rst_outputs", {m_tvalid, m_tlast, busy, done}, 4'b0000);
    check("rst_tdata", m_tdata, 0);
    check("rst_beat_idx", beat_idx, 0);
    check("rst_pkt_count", pkt_count, 0);
    rst = 1'b1;
    tick();

    // table vectors run back-to-back: each command issued in the previous done cycle
    foreach (vecs[i]) begin
      rnd_rdy = vecs[i].rnd;
      send(vecs[i].len, vecs[i].seed, vecs[i].busy_k, n);
      check($sformatf("v%0d_beats", i), got.size(), vecs[i].exp_beats);
      if (vecs[i].exp_beats > 0 && got.size() == vecs[i].exp_beats) begin
        check($sformatf("v%0d_first", i), got[0].d, vecs[i].exp_first);
        check($sformatf("v%0d_lastd", i), got[got.size()-1].d, vecs[i].exp_lastd);
      end
      if (!vecs[i].rnd && vecs[i].len != 0)
        check($sformatf("v%0d_no_bubble", i), n, vecs[i].len);
    end
    check("b2b_pkt_count", pkt_count, 16'd5);

    // backpressure pattern lines up with the cycles where beats are presented
    rnd_rdy = 0;
    tick();
    rdy_pat = '{0, 0, 1, 0, 1, 1};
    send(16'd3, 32'hA0, -1, n);
    check("bp_cycles", n, 6);

    // asynchronous reset while beat 2 of 5 is presented
    start = 1'b1; pkt_len = 16'd5; seed = 32'h200;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && beat_idx != 16'd2; i++) tick();
    check("mid_beat_idx", beat_idx, 16'd2);
    #2 rst = 1'b0;
    #1;
    check("async_rst_ctrl", {m_tvalid, m_tlast, busy, done}, 4'b0000);
    check("async_rst_cnt", pkt_count, 0);
    exp_cnt = 0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    send(16'd3, 32'h300, -1, n);

    // randomized commands, random backpressure and gaps
    rnd_rdy = 1;
    for (int k = 0; k < 40; k++) begin
      logic [15:0] len;
      len = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      send(len, $urandom, -1, n);
      repeat ($urandom_range(0, 2)) tick();
    end

    check("done_pulses", done_total, exp_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
